// File: rtl/vga_pkg.sv
// Shared constants and helpers for the banded VGA controller.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_COLOR_W  = 8;

   typedef enum logic {
      MODE_ROWS = 1'b0,
      MODE_COLS = 1'b1
   } band_mode_e;

   // Bit offset of band k inside the packed {R,G,B} colour bus.
   function automatic int band_offset(input int band, input int color_w);
      return band * 3 * color_w;
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters with sync, blank and active x/y decode.
// Decoded values are registered once (pipeline stage 1); raw counters are also exported.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE = VGA_H_ACTIVE,
   parameter int   H_FP     = VGA_H_FP,
   parameter int   H_SYNC   = VGA_H_SYNC,
   parameter int   H_BP     = VGA_H_BP,
   parameter int   V_ACTIVE = VGA_V_ACTIVE,
   parameter int   V_FP     = VGA_V_FP,
   parameter int   V_SYNC   = VGA_V_SYNC,
   parameter int   V_BP     = VGA_V_BP,
   parameter logic SYNC_POL = 1'b0,
   localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int  HW       = $clog2(H_TOTAL),
   localparam int  VW       = $clog2(V_TOTAL),
   localparam int  XW       = $clog2(H_ACTIVE),
   localparam int  YW       = $clog2(V_ACTIVE)
)(
   input  logic          clk,
   input  logic          rst_n,
   output logic [HW-1:0] h_cnt,
   output logic [VW-1:0] v_cnt,
   output logic          line_end,
   output logic          hs,
   output logic          vs,
   output logic          blank_n,
   output logic          frame_start,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y
);

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          blank_n_q, blank_n_d;
   logic          frame_start_q, frame_start_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          active;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q           <= '0;
         v_q           <= '0;
         hs_q          <= ~SYNC_POL;
         vs_q          <= ~SYNC_POL;
         blank_n_q     <= 1'b0;
         frame_start_q <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         blank_n_q     <= blank_n_d;
         frame_start_q <= frame_start_d;
         x_q           <= x_d;
         y_q           <= y_d;
      end
   end

   always_comb begin
      line_end = (h_q == HW'(H_TOTAL - 1));
      h_d      = line_end ? '0 : h_q + HW'(1);
      v_d      = v_q;
      if (line_end) begin
         v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
      end

      active = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
      hs_d   = ((int'(h_q) >= H_ACTIVE + H_FP) && (int'(h_q) < H_ACTIVE + H_FP + H_SYNC))
               ? SYNC_POL : ~SYNC_POL;
      // VS changes only with v, so its edges line up with h = 0.
      vs_d   = ((int'(v_q) >= V_ACTIVE + V_FP) && (int'(v_q) < V_ACTIVE + V_FP + V_SYNC))
               ? SYNC_POL : ~SYNC_POL;
      blank_n_d     = active;
      frame_start_d = (h_q == '0) && (v_q == '0);
      x_d           = active ? h_q[XW-1:0] : '0;
      y_d           = active ? v_q[YW-1:0] : '0;
   end

   assign h_cnt       = h_q;
   assign v_cnt       = v_q;
   assign hs          = hs_q;
   assign vs          = vs_q;
   assign blank_n     = blank_n_q;
   assign frame_start = frame_start_q;
   assign x           = x_q;
   assign y           = y_q;

endmodule

// File: rtl/vga_band_controller.sv
// Parametrised VGA timing plus NUM_BANDS equal colour bands (stacked rows or side-by-side columns).
// Colours and mode are shadowed once per frame at the start of vertical blanking.
module vga_band_controller
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE  = VGA_H_ACTIVE,
   parameter int   H_FP      = VGA_H_FP,
   parameter int   H_SYNC    = VGA_H_SYNC,
   parameter int   H_BP      = VGA_H_BP,
   parameter int   V_ACTIVE  = VGA_V_ACTIVE,
   parameter int   V_FP      = VGA_V_FP,
   parameter int   V_SYNC    = VGA_V_SYNC,
   parameter int   V_BP      = VGA_V_BP,
   parameter int   NUM_BANDS = 3,
   parameter int   COLOR_W   = VGA_COLOR_W,
   parameter logic SYNC_POL  = 1'b0,
   localparam int  XW        = $clog2(H_ACTIVE),
   localparam int  YW        = $clog2(V_ACTIVE),
   localparam int  RGB_W     = NUM_BANDS * 3 * COLOR_W
)(
   input  logic               iVGA_CLK,
   input  logic               iRST_n,
   input  logic               iMODE,
   input  logic [RGB_W-1:0]   iBAND_RGB,
   output logic               oHS,
   output logic               oVS,
   output logic               oBLANK_n,
   output logic [COLOR_W-1:0] r_data,
   output logic [COLOR_W-1:0] g_data,
   output logic [COLOR_W-1:0] b_data,
   output logic [XW-1:0]      oX,
   output logic [YW-1:0]      oY,
   output logic               oFRAME_START
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int AW      = $clog2((H_ACTIVE > V_ACTIVE) ? H_ACTIVE : V_ACTIVE) + 1;
   localparam int BW      = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
   localparam int PIX_W   = 3 * COLOR_W;

   logic [HW-1:0]      h_cnt;
   logic [VW-1:0]      v_cnt;
   logic               line_end;
   logic               hs_s1, vs_s1, blank_n_s1, frame_start_s1;
   logic [XW-1:0]      x_s1;
   logic [YW-1:0]      y_s1;

   logic [AW-1:0]      row_acc_q, row_acc_d, row_sum;
   logic [AW-1:0]      col_acc_q, col_acc_d, col_sum;
   logic [BW-1:0]      row_band_q, row_band_d;
   logic [BW-1:0]      col_band_q, col_band_d;
   logic [BW-1:0]      band_s1_q, band_s1_d;
   logic [RGB_W-1:0]   rgb_q, rgb_d;
   band_mode_e         mode_q, mode_d;
   logic               shadow_load;

   logic               hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
   logic               frame_start_q, frame_start_d;
   logic [XW-1:0]      x_q, x_d;
   logic [YW-1:0]      y_q, y_d;
   logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
   logic [PIX_W-1:0]   pix;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
      .SYNC_POL (SYNC_POL)
   ) u_timing (
      .clk         (iVGA_CLK),
      .rst_n       (iRST_n),
      .h_cnt       (h_cnt),
      .v_cnt       (v_cnt),
      .line_end    (line_end),
      .hs          (hs_s1),
      .vs          (vs_s1),
      .blank_n     (blank_n_s1),
      .frame_start (frame_start_s1),
      .x           (x_s1),
      .y           (y_s1)
   );

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         row_acc_q     <= '0;
         row_band_q    <= '0;
         col_acc_q     <= '0;
         col_band_q    <= '0;
         band_s1_q     <= '0;
         rgb_q         <= '0;
         mode_q        <= MODE_ROWS;
         hs_q          <= ~SYNC_POL;
         vs_q          <= ~SYNC_POL;
         blank_n_q     <= 1'b0;
         frame_start_q <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         r_q           <= '0;
         g_q           <= '0;
         b_q           <= '0;
      end else begin
         row_acc_q     <= row_acc_d;
         row_band_q    <= row_band_d;
         col_acc_q     <= col_acc_d;
         col_band_q    <= col_band_d;
         band_s1_q     <= band_s1_d;
         rgb_q         <= rgb_d;
         mode_q        <= mode_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         blank_n_q     <= blank_n_d;
         frame_start_q <= frame_start_d;
         x_q           <= x_d;
         y_q           <= y_d;
         r_q           <= r_d;
         g_q           <= g_d;
         b_q           <= b_d;
      end
   end

   // Bresenham band tracking: acc holds pos*NUM_BANDS mod ACTIVE, band the quotient.
   always_comb begin
      row_sum    = row_acc_q + AW'(NUM_BANDS);
      col_sum    = col_acc_q + AW'(NUM_BANDS);
      row_acc_d  = row_acc_q;
      row_band_d = row_band_q;
      col_acc_d  = col_acc_q;
      col_band_d = col_band_q;
      if (line_end) begin
         col_acc_d  = '0;
         col_band_d = '0;
         if (int'(v_cnt) == V_TOTAL - 1) begin
            row_acc_d  = '0;
            row_band_d = '0;
         end else if (int'(v_cnt) < V_ACTIVE - 1) begin
            if (row_sum >= AW'(V_ACTIVE)) begin
               row_acc_d  = row_sum - AW'(V_ACTIVE);
               row_band_d = row_band_q + BW'(1);
            end else begin
               row_acc_d  = row_sum;
            end
         end
      end else if (int'(h_cnt) < H_ACTIVE - 1) begin
         if (col_sum >= AW'(H_ACTIVE)) begin
            col_acc_d  = col_sum - AW'(H_ACTIVE);
            col_band_d = col_band_q + BW'(1);
         end else begin
            col_acc_d  = col_sum;
         end
      end

      shadow_load = (h_cnt == '0) && (int'(v_cnt) == V_ACTIVE);
      rgb_d       = shadow_load ? iBAND_RGB : rgb_q;
      mode_d      = shadow_load ? band_mode_e'(iMODE) : mode_q;
      band_s1_d   = (mode_q == MODE_COLS) ? col_band_q : row_band_q;
   end

   always_comb begin
      pix = '0;
      for (int k = 0; k < NUM_BANDS; k++) begin
         if (band_s1_q == BW'(k)) begin
            pix = rgb_q[band_offset(k, COLOR_W) +: PIX_W];
         end
      end
      if (!blank_n_s1) begin
         pix = '0;
      end
      r_d           = pix[3*COLOR_W-1 -: COLOR_W];
      g_d           = pix[2*COLOR_W-1 -: COLOR_W];
      b_d           = pix[COLOR_W-1:0];
      hs_d          = hs_s1;
      vs_d          = vs_s1;
      blank_n_d     = blank_n_s1;
      frame_start_d = frame_start_s1;
      x_d           = x_s1;
      y_d           = y_s1;
   end

   assign oHS          = hs_q;
   assign oVS          = vs_q;
   assign oBLANK_n     = blank_n_q;
   assign oFRAME_START = frame_start_q;
   assign oX           = x_q;
   assign oY           = y_q;
   assign r_data       = r_q;
   assign g_data       = g_q;
   assign b_data       = b_q;

endmodule

// File: doc/vga_band_controller.md
Name: vga_band_controller

Overview:
- Parametrised VGA timing and pixel generator. Successor to the fixed 640x480 controller: same role between the pixel source and the DAC/VGA pins.
- Timing generation is integrated and parametrised, with selectable sync polarity.
- Splits the active area into NUM_BANDS equal horizontal or vertical bands, each with its own colour.
- Colours and mode are latched once per frame into shadow registers, so changes never cause tearing. Blanked pixels are always black.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
NUM_BANDS, 3, number of colour bands; legal 1..8, must be <= H_ACTIVE and <= V_ACTIVE
COLOR_W, 8, bits per colour channel
SYNC_POL, 0, sync active level (0 = active-low)

Ports:
iVGA_CLK  in  1  pixel clock; all logic on rising edge
iRST_n  in  1  asynchronous, active-low reset
iMODE  in  1  0 = bands stacked by row, 1 = bands side by side by column
iBAND_RGB  in  NUM_BANDS*3*COLOR_W  band k occupies bits [k*3*COLOR_W +: 3*COLOR_W], ordered {R,G,B}, R in the MSBs
oHS  out  1  horizontal sync
oVS  out  1  vertical sync
oBLANK_n  out  1  high during the active area
r_data  out  COLOR_W  red
g_data  out  COLOR_W  green
b_data  out  COLOR_W  blue
oX  out  clog2(H_ACTIVE)  pixel column (valid when oBLANK_n=1)
oY  out  clog2(V_ACTIVE)  pixel row (valid when oBLANK_n=1)
oFRAME_START  out  1  one-cycle pulse for pixel (0,0)

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.
- Horizontal counter h: counts 0..H_TOTAL-1, then wraps to 0.
- Vertical counter v: increments when h wraps; wraps to 0 after V_TOTAL-1.
- Active area: h < H_ACTIVE and v < V_ACTIVE.
- HS is at its active level for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- VS is at its active level for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for whole lines, with its edges at h = 0.
- Band index, division-free (Bresenham accumulator):
  - Mode 0: on each active-line wrap, acc += NUM_BANDS. If acc >= V_ACTIVE, then acc -= V_ACTIVE and band++.
  - Mode 0: acc and band are cleared at v = 0.
  - Mode 1: the same rule is applied per active pixel against H_ACTIVE; acc and band are cleared at every h = 0.
  - Result: band = floor(pos*NUM_BANDS/ACTIVE). Band never exceeds NUM_BANDS-1. Bands are contiguous, with no gap pixels.
- Shadow registers (iBAND_RGB, iMODE):
  - Load on the single cycle h = 0, v = V_ACTIVE (start of vertical blanking).
  - Hold for the whole following frame; mid-frame input changes have no effect until the next load.
- Pipeline:
  - Stage 1 registers sync, blank, x/y, band index and frame-start.
  - Stage 2 looks up the colour and registers it.
  - All outputs are mutually aligned, with 2 clocks latency from the counters.
  - oX/oY/colour on any cycle describe the same pixel.
- Blanking: when oBLANK_n = 0, r/g/b = 0.
- Reset values (while iRST_n = 0):
  - h, v, acc, band = 0; shadow colours and mode = 0.
  - oHS and oVS at their inactive level (~SYNC_POL); oBLANK_n = 0; r/g/b = 0; oX = oY = 0; oFRAME_START = 0.
- Reset mid-frame:
  - Immediate asynchronous clear to the values above.
  - After release, timing restarts at h = v = 0. The first oFRAME_START appears 2 clocks after the first clock edge.
  - Shadow registers stay 0 until the first vertical-blank load, so the first frame is black.
- Widths: counters are clog2(H_TOTAL) and clog2(V_TOTAL) bits; acc is clog2(max ACTIVE)+1 bits; band is max(1, clog2(NUM_BANDS)) bits.

Decomposition:
- Package vga_pkg holds:
  - default 640x480@60 timing constants;
  - MODE_ROWS = 0 and MODE_COLS = 1;
  - a COLOR_W default;
  - a function for the band field offset.
- Sub-module vga_timing_gen holds the h/v counters, sync/blank decode and active x/y, with stage-1 registering. The band accumulator, shadow registers and colour stage stay in the top level.

Test Plan:
- Reset: hold iRST_n = 0 for 10 clocks -> oHS = oVS = 1, oBLANK_n = 0, rgb = 0. Release -> oFRAME_START pulses exactly 2 clocks after the first edge, and the first frame is all black.
- Default timing:
  - oHS falling-edge period is 800 clocks, with oHS low for 96.
  - oVS low for 1600 clocks; frame period is 420000 clocks.
  - oBLANK_n high for 640 clocks per line on 480 lines.
- Row bands, N = 3, colours FF0000 / 00FF00 / 0000FF, second frame:
  - lines 0-159 red, 160-319 green, 320-479 blue;
  - line 159 pixel 639 is red and line 160 pixel 0 is green;
  - no black pixels inside the active area.
- Column mode, N = 4, second frame: x = 159 -> band 0, x = 160 -> band 1, x = 479 -> band 2, x = 480 -> band 3, on every active line.
- Non-divisible, V_ACTIVE = 10, N = 3, with small porches -> band 0 on rows 0-3, band 1 on rows 4-6, band 2 on rows 7-9.
- Shadow: change iBAND_RGB and iMODE at line 100 -> output unchanged through line 479, new values from the next frame's pixel (0,0). Async reset asserted mid-line (h = 300) -> all outputs reach reset values in the same cycle.
